// File: rtl/booth_pkg.sv
// Booth multiplier shared definitions: controller states, widths and
// the radix-2 recoding of the {Q0, Q-1} pair.
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EVAL,
    SHIFT,
    FIN
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP,
    OP_ADD,
    OP_SUB
  } booth_op_t;

  localparam int N_BIT_DEF = 8;
  localparam int CNT_W = $clog2(N_BIT_DEF + 1);

  // 01 ends a run of ones (add), 10 starts one (subtract).
  function automatic booth_op_t booth_op(input logic [1:0] q_pair);
    booth_op_t op;
    op = OP_NOP;
    if (q_pair == 2'b01) op = OP_ADD;
    if (q_pair == 2'b10) op = OP_SUB;
    return op;
  endfunction

endpackage

// File: rtl/booth_iter_cnt.sv
// Iteration counter: loads N_BIT, counts down to zero and stops there.
// last flags the value that becomes zero on the next decrement.
module booth_iter_cnt
  import booth_pkg::*;
#(
  parameter int N_BIT = N_BIT_DEF,
  parameter int W = $clog2(N_BIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero,
  output logic last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(N_BIT);
    end else if (dec && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
  assign last = (cnt == W'(1));

endmodule

// File: rtl/booth_ctrl.sv
// Radix-2 Booth multiplier sequencer: drives load/add/sub/shift strobes
// into the product datapath and reports busy/done.
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int N_BIT = N_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] q_pair,
  output logic       load_s,
  output logic       add_s,
  output logic       sub_s,
  output logic       ashift_s,
  output logic       busy,
  output logic       done
);

  state_t state;
  state_t nxt;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_zero;
  logic   cnt_last;

  booth_iter_cnt #(
    .N_BIT(N_BIT)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .load(cnt_load),
    .dec (cnt_dec),
    .zero(cnt_zero),
    .last(cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt      = state;
    load_s   = 1'b0;
    add_s    = 1'b0;
    sub_s    = 1'b0;
    ashift_s = 1'b0;
    done     = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) nxt = LOAD;
      end
      LOAD: begin
        load_s   = 1'b1;
        cnt_load = 1'b1;
        nxt      = EVAL;
      end
      EVAL: begin
        add_s = (booth_op(q_pair) == OP_ADD);
        sub_s = (booth_op(q_pair) == OP_SUB);
        nxt   = SHIFT;
      end
      SHIFT: begin
        ashift_s = 1'b1;
        cnt_dec  = 1'b1;
        nxt      = (cnt_last || cnt_zero) ? FIN : EVAL;
      end
      FIN: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
    // Cancel only redirects the next state; strobes follow the current one.
    if (abort && state != IDLE) nxt = IDLE;
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: datapath model, vector table of products,
// plus reset, abort and back-to-back sequences.
module tb_booth_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [1:0] q_pair;
  logic load_s, add_s, sub_s, ashift_s, busy, done;

  logic start2 = 1'b0;
  logic load2, add2, sub2, ash2, busy2, done2;

  always #5 clk = ~clk;

  booth_ctrl #(.N_BIT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .q_pair(q_pair), .load_s(load_s), .add_s(add_s),
    .sub_s(sub_s), .ashift_s(ashift_s), .busy(busy), .done(done)
  );

  booth_ctrl #(.N_BIT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
    .q_pair(2'b01), .load_s(load2), .add_s(add2),
    .sub_s(sub2), .ashift_s(ash2), .busy(busy2), .done(done2)
  );

  // Datapath model with a guard bit in the accumulator.
  logic [7:0] op1_v = '0;
  logic [7:0] op2_v = '0;
  logic [8:0] acc = '0;
  logic [7:0] q = '0;
  logic [7:0] m = '0;
  logic       qm1 = 1'b0;

  assign q_pair = {q[0], qm1};

  always @(posedge clk) begin
    if (load_s) begin
      acc <= '0; q <= op2_v; qm1 <= 1'b0; m <= op1_v;
    end else if (add_s) begin
      acc <= acc + {m[7], m};
    end else if (sub_s) begin
      acc <= acc - {m[7], m};
    end else if (ashift_s) begin
      {acc, q, qm1} <= {acc[8], acc, q};
    end
  end

  int pass_cnt = 0;
  int total = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    logic [15:0] seq;
    int          adds;
    int          subs;
  } vec_t;

  int lat, n_add, n_sub, n_sh, viol;
  logic [15:0] seq_p;

  task automatic run_op(input logic [7:0] a, input logic [7:0] b);
    logic [1:0] prev, code;
    int idx;
    op1_v = a; op2_v = b;
    lat = 0; n_add = 0; n_sub = 0; n_sh = 0; viol = 0;
    seq_p = '0; prev = '0; idx = 0;
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 5) start = 1'b1;
      if (k == 7) start = 1'b0;
      code = add_s ? 2'd1 : (sub_s ? 2'd2 : 2'd0);
      if ($countones({load_s, add_s, sub_s, ashift_s}) > 1) viol++;
      if (add_s) n_add++;
      if (sub_s) n_sub++;
      if (ashift_s) begin
        if (idx < 8) seq_p[2*idx +: 2] = prev;
        idx++;
        n_sh++;
      end
      prev = code;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic wait_done(input string name);
    int got;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    chk(name, got, 1);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'd15, 8'd23, 16'd345, 16'h0642, 2, 2};
    vecs[1] = '{8'd15, 8'd0, 16'd0, 16'h0000, 0, 0};
    vecs[2] = '{8'h80, 8'h80, 16'h4000, 16'h8000, 0, 1};
    vecs[3] = '{8'hFD, 8'd5, 16'hFFF1, 16'h0066, 2, 2};
    vecs[4] = '{8'd7, 8'hFF, 16'hFFF9, 16'h0002, 0, 1};

    // Reset held two cycles with start high.
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset_outs", {load_s, add_s, sub_s, ashift_s, busy, done}, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_load", load_s, 1);
    start = 1'b0;
    wait_done("post_reset_done");
    @(negedge clk);
    chk("post_reset_idle", busy, 0);

    for (int v = 0; v < 5; v++) begin
      run_op(vecs[v].a, vecs[v].b);
      chk($sformatf("lat_%0d", v), lat, 18);
      chk($sformatf("prod_%0d", v), {acc[7:0], q}, vecs[v].prod);
      chk($sformatf("seq_%0d", v), seq_p, vecs[v].seq);
      chk($sformatf("adds_%0d", v), n_add, vecs[v].adds);
      chk($sformatf("subs_%0d", v), n_sub, vecs[v].subs);
      chk($sformatf("shifts_%0d", v), n_sh, 8);
      chk($sformatf("onehot_%0d", v), viol, 0);
      @(negedge clk);
      chk($sformatf("idle_%0d", v), {busy, load_s}, 0);
    end

    // Abort in the fifth SHIFT.
    begin
      int sh, dn;
      sh = 0; dn = 0;
      op1_v = 8'd15; op2_v = 8'd23;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < 40; k++) begin
        if (ashift_s) sh++;
        if (sh == 5) break;
        @(negedge clk);
      end
      chk("abort_reached_shift5", {ashift_s, 31'(sh)}, {1'b1, 31'd5});
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_idle", {busy, done}, 0);
      for (int k = 0; k < 25; k++) begin
        @(negedge clk);
        if (done || busy) dn++;
      end
      chk("abort_no_done", dn, 0);
      run_op(8'd15, 8'd23);
      chk("abort_rerun_lat", lat, 18);
      chk("abort_rerun_prod", {acc[7:0], q}, 16'd345);
    end

    // start and abort together in IDLE.
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("start_abort_idle", {busy, load_s}, 0);
    start = 1'b0; abort = 1'b0;

    // Reset mid-run with start held high, then back-to-back runs.
    begin
      int l2;
      l2 = 0;
      @(negedge clk); start = 1'b1;
      repeat (9) @(negedge clk);
      chk("pre_reset_busy", busy, 1);
      #1 rst = 1'b1;
      #1;
      chk("async_reset_outs",
          {load_s, add_s, sub_s, ashift_s, busy, done}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_rerun_load", load_s, 1);
      for (int k = 2; k <= 40; k++) begin
        @(negedge clk);
        if (done) begin l2 = k; break; end
      end
      chk("rst_rerun_lat", l2, 18);
      @(negedge clk);
      chk("b2b_gap_idle", busy, 0);
      @(negedge clk);
      chk("b2b_restart_load", load_s, 1);
      start = 1'b0;
      wait_done("b2b_done");
      @(negedge clk);
    end

    // N_BIT = 2 instance.
    begin
      int l3, adds;
      l3 = 0; adds = 0;
      @(negedge clk); start2 = 1'b1;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (k == 1) start2 = 1'b0;
        if (add2) adds++;
        if (done2) begin l3 = k; break; end
      end
      chk("nbit2_lat", l3, 6);
      chk("nbit2_adds", adds, 2);
      @(negedge clk);
      chk("nbit2_idle", busy2, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
